// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO with occupancy count, programmable almost-full/empty
// flags, overflow/underflow pulses and a selectable standard or first-word-fall-through read.
module fifo_flagged #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_flagged: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_ptr_reg;
  logic [ADDR_WIDTH-1:0] r_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  empty_reg;
  logic                  full_reg;
  logic                  almost_empty_reg;
  logic                  almost_full_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic wr_acc;
  logic rd_acc;

  // A write into a full FIFO is still taken when a read frees the slot on the same edge.
  assign wr_acc = write & (~full_reg | read);
  assign rd_acc = read & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_reg        <= '0;
      r_ptr_reg        <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_ptr_reg <= w_ptr_reg + 1'b1;
      end
      if (rd_acc) begin
        r_ptr_reg <= r_ptr_reg + 1'b1;
      end
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == DEPTH_CNT);
      almost_empty_reg <= (count_next <= AE_CNT);
      almost_full_reg  <= (count_next >= AF_CNT);
      overflow_reg     <= write & full_reg & ~read;
      underflow_reg    <= read & empty_reg;
    end
  end

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_ptr_reg] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem[r_ptr_reg];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_out_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_out_reg <= '0;
      end else if (rd_acc) begin
        data_out_reg <= mem[r_ptr_reg];
      end
    end
    assign data_out = data_out_reg;
  end

  assign count        = count_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_empty = almost_empty_reg;
  assign almost_full  = almost_full_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_flagged.sv
// Scoreboard bench: one standard-read and one FWFT instance share stimulus and are
// checked against a queue-based reference model.
module tb_fifo_flagged;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout [2];
  logic [4:0] cnt  [2];
  logic       emp  [2];
  logic       ful  [2];
  logic       ae   [2];
  logic       af   [2];
  logic       ovf  [2];
  logic       unf  [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    fifo_flagged #(.FWFT(gi)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .read         (rd),
      .write        (wr),
      .data_in      (din),
      .data_out     (dout[gi]),
      .empty        (emp[gi]),
      .full         (ful[gi]),
      .almost_empty (ae[gi]),
      .almost_full  (af[gi]),
      .count        (cnt[gi]),
      .overflow     (ovf[gi]),
      .underflow    (unf[gi])
    );
  end

  typedef struct {
    int       cnt;
    bit       ovf;
    bit       unf;
    bit [7:0] std_data;
    bit [7:0] head;
  } exp_t;

  exp_t     sb [$];
  bit [7:0] mq [$];
  bit [7:0] last_out;
  int       checks = 0;
  int       errors = 0;
  int       txn = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the FIFO is just a queue; rules are applied to the pre-edge size.
  task automatic step(bit r, bit w, bit [7:0] d);
    exp_t e;
    int   n;
    bit   wa, ra;
    @(negedge clk);
    rd = r; wr = w; din = d;
    n  = mq.size();
    wa = w && (n < 16 || r);
    ra = r && n > 0;
    e.ovf = w && n == 16 && !r;
    e.unf = r && n == 0;
    if (ra) last_out = mq.pop_front();
    if (wa) mq.push_back(d);
    e.cnt      = mq.size();
    e.std_data = last_out;
    e.head     = (mq.size() > 0) ? mq[0] : 8'h00;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d cnt=%0d std_out=%h fwft_out=%h ovf=%0b unf=%0b",
                 txn, cnt[0], dout[0], dout[1], ovf[0], unf[0]);
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("count m%0d t%0d", m, txn), 32'(cnt[m]), 32'(e.cnt));
          chk($sformatf("empty m%0d t%0d", m, txn), 32'(emp[m]), 32'(e.cnt == 0));
          chk($sformatf("full m%0d t%0d", m, txn), 32'(ful[m]), 32'(e.cnt == 16));
          chk($sformatf("almost_empty m%0d t%0d", m, txn), 32'(ae[m]), 32'(e.cnt <= 2));
          chk($sformatf("almost_full m%0d t%0d", m, txn), 32'(af[m]), 32'(e.cnt >= 14));
          chk($sformatf("overflow m%0d t%0d", m, txn), 32'(ovf[m]), 32'(e.ovf));
          chk($sformatf("underflow m%0d t%0d", m, txn), 32'(unf[m]), 32'(e.unf));
        end
        chk($sformatf("std_data t%0d", txn), 32'(dout[0]), 32'(e.std_data));
        if (e.cnt > 0) chk($sformatf("fwft_head t%0d", txn), 32'(dout[1]), 32'(e.head));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  task automatic fill_seq(bit [7:0] base);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, base + 8'(i));
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin : driver
    int wp;
    last_out = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_count m%0d", m), 32'(cnt[m]), 0);
      chk($sformatf("rst_empty m%0d", m), 32'(emp[m]), 1);
      chk($sformatf("rst_full m%0d", m), 32'(ful[m]), 0);
      chk($sformatf("rst_ae m%0d", m), 32'(ae[m]), 1);
      chk($sformatf("rst_af m%0d", m), 32'(af[m]), 0);
      chk($sformatf("rst_ovf m%0d", m), 32'(ovf[m]), 0);
      chk($sformatf("rst_unf m%0d", m), 32'(unf[m]), 0);
    end
    chk("rst_std_data", 32'(dout[0]), 0);

    // Ramp up and down
    fill_seq(8'h00);
    drain(16);
    step(1'b0, 1'b0, 8'h00);
    // Overflow on full
    fill_seq(8'h00);
    step(1'b0, 1'b1, 8'hAA);
    drain(16);
    step(1'b0, 1'b0, 8'h00);
    // Underflow, then read+write on empty
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    // Simultaneous read+write while full, pointers wrap
    fill_seq(8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h77);
    drain(16);
    step(1'b0, 1'b0, 8'h00);
    // Single word fall-through
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Random traffic with phases biased toward full and toward empty
    for (int p = 0; p < 4; p++) begin
      wp = (p % 2 == 0) ? 80 : 20;
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) >= 100 - (100 - wp),
             $urandom_range(0, 99) < wp,
             8'($urandom));
      end
    end

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i));
    @(posedge clk);
    #3;
    chk("sb_empty_before_reset", 32'(sb.size()), 0);
    reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("async_rst_count m%0d", m), 32'(cnt[m]), 0);
      chk($sformatf("async_rst_empty m%0d", m), 32'(emp[m]), 1);
    end
    chk("async_rst_std_data", 32'(dout[0]), 0);
    wr = 1'b0;
    rd = 1'b0;
    mq.delete();
    last_out = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'h5B);
    drain(3);
    step(1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Parametrised synchronous FIFO, the successor to the basic read/write/empty/full FIFO. It adds an occupancy count, programmable almost-full and almost-empty flags, one-cycle overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It serves as a drop-in buffer between producer and consumer blocks on a single clock domain.

Parameters:
ADDR_WIDTH, 4, address bits; depth DEPTH = 2**ADDR_WIDTH entries, all usable.
DATA_WIDTH, 8, width of each stored word.
AF_LEVEL, 2**ADDR_WIDTH-2, almost_full is asserted when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty is asserted when count <= AE_LEVEL.
FWFT, 0, read mode: 0 = registered standard read, 1 = first-word-fall-through.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
read  in  1  read request.
write  in  1  write request.
data_in  in  DATA_WIDTH  write data.
data_out  out  DATA_WIDTH  read data.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
almost_empty  out  1  count <= AE_LEVEL.
almost_full  out  1  count >= AF_LEVEL.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  one-cycle pulse: write was dropped.
underflow  out  1  one-cycle pulse: read was dropped.

Behaviour:
- Reset (asynchronous, active-high) clears the pointers and sets count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. In FWFT=0 mode, data_out=0. Memory contents are not reset.
- Accept rules:
  - wr_acc = write & (!full | read).
  - rd_acc = read & !empty.
  - Both rules use the registered pre-edge flags.
- Pointers: w_ptr advances on wr_acc and r_ptr advances on rd_acc. Each pointer is ADDR_WIDTH bits and wraps from DEPTH-1 to 0 with no special case.
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged otherwise.
  - All flags are registered and derived from the next-state count, so they are valid in the same cycle as count.
- Simultaneous read and write:
  - Full: both are accepted, count stays at DEPTH, full stays 1, no overflow.
  - Empty: the write is accepted, the read is rejected, underflow pulses, count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- overflow is registered and equals 1 for the cycle after the edge where write & full & !read. The data is discarded and the memory is untouched.
- underflow is registered and equals 1 for the cycle after the edge where read & empty. data_out holds its previous value.
- FWFT=0 read path: on rd_acc, data_out is loaded at that edge with mem[r_ptr], so data is visible 1 cycle after read is sampled. data_out holds between reads.
- FWFT=1 read path: data_out = mem[r_ptr] (combinational from storage). It is valid whenever empty=0 and undefined (don't care) when empty=1. read acts as "consume the head". A word written into an empty FIFO appears on data_out the cycle after the write edge, together with empty falling.
- Write-to-read: a word written at edge N is readable (rd_acc possible) from edge N+1.
- Legal parameters: 1 <= AE_LEVEL < AF_LEVEL <= DEPTH. An elaboration-time assertion checks this.
- Reset asserted mid-operation discards all contents immediately. The first accepted write after reset release lands at address 0.

Test Plan:
- Reset, then idle → empty=1, almost_empty=1, count=0, full=0, almost_full=0, overflow=underflow=0, data_out=0 (FWFT=0).
- Write 16 words 0x00..0x0F, then read 16 (FWFT=0, defaults):
  - count ramps 0→16 and back to 0.
  - almost_empty falls when count=3; almost_full rises at count=14; full=1 at count=16.
  - data_out sequence is 0x00..0x0F, each word one cycle after its read.
- With the FIFO full, assert write with data 0xAA for one cycle:
  - overflow=1 for exactly one cycle; count stays 16.
  - Draining yields 0x00..0x0F with no 0xAA.
- With the FIFO empty:
  - Read alone: underflow pulses once, count=0.
  - Read+write of 0x55: underflow pulses, count=1, and a subsequent read returns 0x55.
- Full plus simultaneous read+write of 0x77 for 4 cycles → full stays 1, count=16, no overflow, outputs 0x00..0x03. The pointers wrap, and the final drain ends with 0x77 ×4.
- FWFT=1:
  - Write 0x3C into the empty FIFO → the next cycle shows empty=0 and data_out=0x3C before any read.
  - read → empty=1 on the following cycle.
  - Assert reset mid-burst → count=0 and empty=1 immediately (asynchronously).
